kbd_serial_tx: RTL and testbench



---
 rtl/kbd_serial_tx.sv | 156 +++++++++++++++
 tb/tb_kbd_serial_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/kbd_serial_tx.sv
// kbd_serial_tx: Amiga keyboard KDAT/KCLK transmitter with CIA handshake and lost-sync recovery; KBD_POWERUP_STREAM_EN sends FD/FE after reset
module kbd_serial_tx #(
  parameter int BIT_TICKS = 142,
  parameter int TIMEOUT_TICKS = 1014412
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk7_en,
  input  logic [7:0] key_data,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       kbd_clk,
  output logic       kbd_dat,
  input  logic       ack_n,
  output logic       busy,
  output logic       resync
);
`ifdef KBD_POWERUP_STREAM_EN
  localparam logic POWERUP = 1'b1;
`else
  localparam logic POWERUP = 1'b0;
`endif
  localparam int PW = BIT_TICKS > 1 ? $clog2(BIT_TICKS) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [PW-1:0] PLAST = PW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS);
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, WAIT_ACK, ACK_REL, RESYNC_BIT, RESYNC_WAIT} state_t;
  typedef enum logic [1:0] {JOB_KEY, JOB_FD, JOB_FE} job_t;
  state_t state;
  job_t job;
  logic [PW-1:0] phase;
  logic [TW-1:0] tcnt, tcnt_inc;
  logic [2:0] bitn;
  logic [1:0] sub;
  logic [7:0] hold, shift, nxt, enc;
  logic pu, f9, go;
  // go starts a byte: a fresh key or powerup code from IDLE, or the follow-up byte after a handshake
  always_comb begin
    go = state == IDLE ? (pu || (key_valid && key_ready))
                       : state == ACK_REL && ack_n && (resync || f9 || job == JOB_FD);
    nxt = state == IDLE ? (pu ? 8'hFD : key_data)
        : resync ? 8'hF9
        : f9 ? (job == JOB_FD ? 8'hFD : job == JOB_FE ? 8'hFE : hold)
        : 8'hFE;
    enc = {~nxt[6:0], ~nxt[7]};
    tcnt_inc = tcnt == TMAX ? tcnt : tcnt + 1'b1;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      job <= JOB_KEY;
      phase <= '0;
      tcnt <= '0;
      bitn <= '0;
      sub <= '0;
      hold <= '0;
      shift <= '0;
      pu <= POWERUP;
      f9 <= 1'b0;
      kbd_clk <= 1'b1;
      kbd_dat <= 1'b1;
      key_ready <= 1'b0;
      busy <= 1'b0;
      resync <= 1'b0;
    end else if (clk7_en) begin
      case (state)
        IDLE: begin
          key_ready <= 1'b1;
          if (go) begin
            pu <= 1'b0;
            job <= pu ? JOB_FD : JOB_KEY;
            if (!pu) hold <= key_data;
          end
        end
        SETUP:
          if (phase == PLAST) begin
            phase <= '0;
            state <= LOW;
            kbd_clk <= 1'b0;
          end else phase <= phase + 1'b1;
        LOW:
          if (phase == PLAST) begin
            phase <= '0;
            state <= HIGH;
            kbd_clk <= 1'b1;
          end else phase <= phase + 1'b1;
        HIGH:
          if (phase == PLAST) begin
            phase <= '0;
            if (bitn == 3'd7) begin
              state <= WAIT_ACK;
              kbd_dat <= 1'b1;
              tcnt <= '0;
            end else begin
              state <= SETUP;
              bitn <= bitn + 1'b1;
              shift <= shift << 1;
              kbd_dat <= shift[6];
            end
          end else phase <= phase + 1'b1;
        // ack is checked before the timeout so an ack in the last counted tick wins
        WAIT_ACK:
          if (!ack_n) begin
            state <= ACK_REL;
            if (f9) resync <= 1'b0;
          end else if (tcnt == TLAST) begin
            state <= RESYNC_BIT;
            resync <= 1'b1;
            kbd_dat <= 1'b0;
            phase <= '0;
            sub <= '0;
          end else tcnt <= tcnt_inc;
        ACK_REL:
          if (ack_n) begin
            if (resync) f9 <= 1'b1;
            else if (f9) f9 <= 1'b0;
            else if (job == JOB_FD) job <= JOB_FE;
            else begin
              state <= IDLE;
              busy <= 1'b0;
              key_ready <= 1'b1;
              job <= JOB_KEY;
            end
          end
        RESYNC_BIT:
          if (phase == PLAST) begin
            phase <= '0;
            sub <= sub + 1'b1;
            kbd_clk <= sub != 2'd0;
            if (sub == 2'd2) begin
              state <= RESYNC_WAIT;
              kbd_dat <= 1'b1;
              tcnt <= '0;
            end
          end else phase <= phase + 1'b1;
        RESYNC_WAIT:
          if (!ack_n) state <= ACK_REL;
          else if (tcnt == TLAST) begin
            state <= RESYNC_BIT;
            kbd_dat <= 1'b0;
            phase <= '0;
            sub <= '0;
          end else tcnt <= tcnt_inc;
      endcase
      if (go) begin
        state <= SETUP;
        phase <= '0;
        bitn <= '0;
        shift <= enc;
        kbd_dat <= enc[7];
        busy <= 1'b1;
        key_ready <= 1'b0;
      end
    end
endmodule

// File: tb/tb_kbd_serial_tx.sv
// tb_kbd_serial_tx: directed vector bench for kbd_serial_tx with short bit and timeout periods
module tb_kbd_serial_tx;
  localparam int B = 4;
  localparam int T = 50;
  logic clk = 1'b0, reset_n = 1'b0, clk7_en = 1'b1, key_valid = 1'b0, ack_n = 1'b1;
  logic [7:0] key_data = 8'h00;
  logic key_ready, kbd_clk, kbd_dat, busy, resync;
  int n_vec = 0, n_err = 0, cyc = 0, fe_n = 0;
  logic fe_lvl [0:255];
  int fe_cyc [0:255];
  logic kclk_q = 1'b1;
  typedef struct { logic [7:0] data; logic [7:0] bits; int ack_d; logic noise; } vec_t;
  vec_t v [6];

  kbd_serial_tx #(.BIT_TICKS(B), .TIMEOUT_TICKS(T)) dut (
    .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en), .key_data(key_data),
    .key_valid(key_valid), .key_ready(key_ready), .kbd_clk(kbd_clk),
    .kbd_dat(kbd_dat), .ack_n(ack_n), .busy(busy), .resync(resync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // record kbd_dat at every kbd_clk falling edge, sampled on the opposite clock edge
  always @(negedge clk) begin
    if (kclk_q && !kbd_clk && fe_n < 256) begin
      fe_lvl[fe_n] <= kbd_dat;
      fe_cyc[fe_n] <= cyc;
      fe_n <= fe_n + 1;
    end
    kclk_q <= kbd_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, output int base);
    key_data = d;
    key_valid = 1'b1;
    base = fe_n;
    step(1);
    key_valid = 1'b0;
  endtask

  function automatic logic [7:0] got_byte(input int base);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = fe_lvl[base+i];
    return r;
  endfunction

  initial begin
    int base;
    logic [26:0] stream;
    v[0] = '{8'h45, 8'b0111_0101, 10, 1'b0};
    v[1] = '{8'hC5, 8'b0111_0100, 1, 1'b0};
    v[2] = '{8'h00, 8'b1111_1111, T, 1'b1};
    v[3] = '{8'hFF, 8'b0000_0000, 5, 1'b0};
    v[4] = '{8'h80, 8'b1111_1110, 3, 1'b1};
    v[5] = '{8'h01, 8'b1111_1101, 20, 1'b0};
    step(3);
    check("rst_clk", kbd_clk, 1);
    check("rst_dat", kbd_dat, 1);
    check("rst_ready", key_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_resync", resync, 0);
    reset_n = 1'b1;
`ifdef KBD_POWERUP_STREAM_EN
    base = fe_n;
    step(1);
    check("pu_ready", key_ready, 0);
    check("pu_busy", busy, 1);
    step(24*B);
    ack_n = 1'b0; step(2); ack_n = 1'b1; step(1);
    check("pu_ready_mid", key_ready, 0);
    step(24*B);
    ack_n = 1'b0; step(2); ack_n = 1'b1; step(1);
    check("pu_fd_bits", got_byte(base), 8'b0000_0100);
    check("pu_fe_bits", got_byte(base+8), 8'b0000_0010);
    check("pu_ready_done", key_ready, 1);
`else
    step(1);
    check("ready_first_tick", key_ready, 1);
    check("idle_busy", busy, 0);
`endif
    step(2);
    for (int i = 0; i < 6; i++) begin
      check("ready_idle", key_ready, 1);
      send(v[i].data, base);
      check("busy_on_accept", busy, 1);
      check("first_bit", kbd_dat, v[i].bits[7]);
      check("ready_low", key_ready, 0);
      if (v[i].noise) begin
        step(5*B);
        ack_n = 1'b0; key_valid = 1'b1; key_data = ~v[i].data;
        step(3);
        ack_n = 1'b1; key_valid = 1'b0;
        step(24*B + v[i].ack_d - 1 - 5*B - 3);
      end else step(24*B + v[i].ack_d - 1);
      check("edges", fe_n - base, 8);
      check("bits", got_byte(base), v[i].bits);
      check("spacing", fe_cyc[base+7] - fe_cyc[base], 21*B);
      check("no_resync", resync, 0);
      ack_n = 1'b0;
      step(1);
      check("ack_no_resync", resync, 0);
      check("busy_ack", busy, 1);
      step(2);
      ack_n = 1'b1;
      step(1);
      check("ready_back", key_ready, 1);
      check("busy_done", busy, 0);
      check("dat_idle", kbd_dat, 1);
      step(2);
    end
    clk7_en = 1'b0;
    key_data = 8'h45; key_valid = 1'b1;
    base = fe_n;
    step(5);
    check("gated_busy", busy, 0);
    check("gated_ready", key_ready, 1);
    clk7_en = 1'b1;
    step(1);
    key_valid = 1'b0;
    check("ungated_busy", busy, 1);
    step(2*B - 1);
    check("gated_low_before", kbd_clk, 0);
    clk7_en = 1'b0;
    step(10);
    check("gated_frozen", kbd_clk, 0);
    clk7_en = 1'b1;
    step(22*B + 1);
    ack_n = 1'b0; step(2); ack_n = 1'b1; step(1);
    check("gated_bits", got_byte(base), 8'b0111_0101);
    check("gated_done", key_ready, 1);
    step(2);
    send(8'h20, base);
    step(24*B + T - 1);
    check("pre_timeout", resync, 0);
    step(1);
    check("resync_rise", resync, 1);
    check("resync_dat", kbd_dat, 0);
    step(2*(3*B + T) + 3*B);
    ack_n = 1'b0;
    check("resync_edges", fe_n - base, 11);
    check("resync_period", fe_cyc[base+10] - fe_cyc[base+9], 3*B + T);
    step(3);
    ack_n = 1'b1;
    step(1);
    check("f9_first_dat", kbd_dat, 0);
    check("f9_resync_high", resync, 1);
    step(24*B + 4);
    ack_n = 1'b0;
    step(1);
    check("resync_drop", resync, 0);
    step(2);
    ack_n = 1'b1;
    step(1);
    check("retx_busy", busy, 1);
    step(24*B + 2);
    ack_n = 1'b0; step(3); ack_n = 1'b1; step(1);
    check("retx_ready", key_ready, 1);
    check("retx_busy_done", busy, 0);
    check("stream_edges", fe_n - base, 27);
    for (int i = 0; i < 27; i++) stream[26-i] = fe_lvl[base+i];
    check("stream_bits", stream, {8'b1011_1111, 3'b000, 8'b0000_1100, 8'b1011_1111});
    step(2);
    send(8'h45, base);
    step(10*B + 1);
    check("mid_low", kbd_clk, 0);
    reset_n = 1'b0;
    step(1);
    check("mid_rst_clk", kbd_clk, 1);
    check("mid_rst_dat", kbd_dat, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", key_ready, 0);
    reset_n = 1'b1;
`ifdef KBD_POWERUP_STREAM_EN
    step(1);
    check("mid_rst_pu_busy", busy, 1);
`else
    base = fe_n;
    step(1);
    check("mid_rst_ready_back", key_ready, 1);
    step(30*B);
    check("no_resend_edges", fe_n - base, 0);
    check("no_resend_busy", busy, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
